// File: rtl/data_structures.sv
// Default queue depth, queue entry layout and control-state encoding shared by the instruction queue.
`ifndef INSN_QUEUE_DEPTH
`define INSN_QUEUE_DEPTH 4
`endif

package data_structures;

  localparam int INSN_QUEUE_DEPTH = `INSN_QUEUE_DEPTH;

  typedef struct packed {
    logic [31:0] insnbits;
    logic [63:0] pc;
  } entry_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/insn_queue.sv
// Fetch-to-dispatch FIFO with a one-cycle write-to-head latency and no bypass.
// Ready to fetch is low when the queue is full or after a zero word; dispatch stalls by holding in_stall.
module insn_queue
  import data_structures::*;
#(
  parameter int DEPTH = INSN_QUEUE_DEPTH
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_fetch_done,
  input  logic [31:0]                in_fetch_insnbits,
  input  logic [63:0]                in_fetch_pc,
  output logic                       out_fetch_ready,
  output logic                       out_d_done,
  output logic [31:0]                out_d_insnbits,
  output logic [63:0]                out_d_pc,
  input  logic                       in_stall,
  input  logic                       in_flush,
  output logic                       out_halt_done,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  state_t        state;
  state_t        state_nxt;
  logic          offer_ok;
  logic          zero_word;
  logic          push;
  logic          pop;

  always_comb begin
    offer_ok  = in_fetch_done && out_fetch_ready && !in_flush;
    zero_word = (in_fetch_insnbits == 32'd0);
    push      = offer_ok && !zero_word;
    pop       = out_d_done && !in_stall && !in_flush;
  end

  // A zero word is the halt marker: it is consumed but never stored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (offer_ok && zero_word) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
    endcase
    if (in_flush) state_nxt = ST_RUN;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state  <= ST_RUN;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (in_flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge in_clk) begin
    if (push) mem[wr_ptr] <= '{insnbits: in_fetch_insnbits, pc: in_fetch_pc};
  end

  always_comb begin
    head            = mem[rd_ptr];
    out_count       = count;
    out_d_done      = (count != '0);
    out_d_insnbits  = out_d_done ? head.insnbits : 32'd0;
    out_d_pc        = out_d_done ? head.pc : 64'd0;
    out_fetch_ready = (count < FULL) && (state == ST_RUN);
    out_halt_done   = (state == ST_HALTED) && (count == '0);
  end

endmodule
